// File: rtl/imem_boot_loader.sv
// Boot-time instruction memory loader: receives a length/data/checksum byte frame,
// writes 32-bit words at sequential addresses and releases the core once verified.
module imem_boot_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0, ERR_LEN = 2'd1, ERR_CSUM = 2'd2, ERR_TIMEOUT = 2'd3
  } err_t;

  localparam int                WW        = ADDR_WIDTH + 1;
  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]       MAX_WORDS = 17'(1 << ADDR_WIDTH);

  state_t            state, state_next;
  logic [7:0]        len_lo;
  logic [15:0]       len_words;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_bytes;
  logic [7:0]        csum;
  logic [IDLE_W-1:0] idle_cnt;

  logic        accept;
  logic        restart;
  logic [15:0] frame_len;
  logic        len_too_big;
  logic        word_done;
  logic        last_word;
  logic        timeout_hit;

  assign accept      = in_valid && in_ready;
  assign restart     = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign frame_len   = {in_data, len_lo};
  assign len_too_big = {1'b0, frame_len} > MAX_WORDS;
  assign word_done   = accept && (state == S_DATA) && (byte_cnt == 2'd3);
  assign last_word   = (32'(words_written) + 32'd1) == 32'(len_words);
  assign timeout_hit = in_ready && !accept && (idle_cnt == IDLE_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first keeps every path assigned, so no latch is inferred.
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_LEN_LO;
      S_LEN_LO: if (accept) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (frame_len == 16'd0) state_next = S_CSUM;
          else if (len_too_big)   state_next = S_ERROR;
          else                    state_next = S_DATA;
        end
      end
      S_DATA:   if (word_done && last_word) state_next = S_CSUM;
      S_CSUM: begin
        if (accept) state_next = (in_data == csum) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: if (start) state_next = S_LEN_LO;
      default:  state_next = S_IDLE;
    endcase
    if (timeout_hit) state_next = S_ERROR;
  end

  always_comb begin
    in_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                (state == S_DATA)   || (state == S_CSUM);
    done      = (state == S_DONE);
    error     = (state == S_ERROR);
    core_hold = (state != S_DONE);
  end

  // Datapath: length capture, word assembly, checksum, write port and idle timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_lo        <= '0;
      len_words     <= '0;
      byte_cnt      <= '0;
      asm_bytes     <= '0;
      csum          <= '0;
      idle_cnt      <= '0;
      err_code      <= ERR_NONE;
      words_written <= '0;
      mem_we        <= 1'b0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
    end else begin
      mem_we   <= 1'b0;
      idle_cnt <= (!in_ready || accept) ? '0 : idle_cnt + IDLE_W'(1);

      if (restart) begin
        err_code      <= ERR_NONE;
        words_written <= '0;
        csum          <= '0;
        byte_cnt      <= '0;
      end

      if (accept) begin
        unique case (state)
          S_LEN_LO: len_lo <= in_data;
          S_LEN_HI: begin
            len_words <= frame_len;
            if (len_too_big) err_code <= ERR_LEN;
          end
          S_DATA: begin
            asm_bytes <= {in_data, asm_bytes[23:8]};
            csum      <= csum + in_data;
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we        <= 1'b1;
              mem_waddr     <= words_written[ADDR_WIDTH-1:0];
              mem_wdata     <= {in_data, asm_bytes};
              words_written <= words_written + WW'(1);
            end
          end
          S_CSUM: if (in_data != csum) err_code <= ERR_CSUM;
          default: ;
        endcase
      end

      if (timeout_hit) err_code <= ERR_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frames, error paths, stall gaps, timeout and mid-frame reset.
module tb_imem_boot_loader;

  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [AW:0]   words_written;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] waddr_q[$];
  logic [31:0]   wdata_q[$];

  imem_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .core_hold(core_hold),
    .done(done), .error(error), .err_code(err_code),
    .words_written(words_written)
  );

  always #5 clock = ~clock;

  // Capture every write strobe away from the active edge.
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      waddr_q.push_back(mem_waddr);
      wdata_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // max_gap > 0 inserts random stalls; long_gap_at puts a 15-cycle stall before that byte.
  task automatic send_seq(input logic [7:0] seq[$], input int max_gap, input int long_gap_at);
    foreach (seq[i]) begin
      if (i == long_gap_at) idle(15);
      else if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
      send_byte(seq[i]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic clear_writes();
    waddr_q.delete();
    wdata_q.delete();
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_nwr"}, 32'(waddr_q.size()), 32'd2);
    if (waddr_q.size() >= 2) begin
      check({tag, "_a0"}, 32'(waddr_q[0]), 32'd0);
      check({tag, "_d0"}, wdata_q[0], 32'h0000_0013);
      check({tag, "_a1"}, 32'(waddr_q[1]), 32'd1);
      check({tag, "_d1"}, wdata_q[1], 32'h0010_0093);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"},    32'(mem_we), 32'd0);
    check({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_hold"},  32'(core_hold), 32'd1);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_code"},  32'(err_code), 32'd0);
    check({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] frame_ok[$]  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    logic [7:0] frame_bad[$] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                 8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
    logic [7:0] frame_big[$] = '{8'h01, 8'h10};
    logic [7:0] frame_nil[$] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] frame_to[$]  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
    logic [7:0] frame_max[$] = '{8'h00, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAA};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_idle_outputs("reset");

    // Two-word image, back-to-back bytes.
    clear_writes();
    pulse_start();
    check("start_ready", 32'(in_ready), 32'd1);
    send_seq(frame_ok, 0, -1);
    check("ok_done",  32'(done), 32'd1);
    check("ok_hold",  32'(core_hold), 32'd0);
    check("ok_error", 32'(error), 32'd0);
    check("ok_words", 32'(words_written), 32'd2);
    check("ok_ready", 32'(in_ready), 32'd0);
    check_two_writes("ok");

    // Bad checksum: writes still happen, then ERROR code 2.
    clear_writes();
    pulse_start();
    check("restart_words", 32'(words_written), 32'd0);
    send_seq(frame_bad, 0, -1);
    check("csum_error", 32'(error), 32'd1);
    check("csum_code",  32'(err_code), 32'd2);
    check("csum_hold",  32'(core_hold), 32'd1);
    check("csum_done",  32'(done), 32'd0);
    check_two_writes("csum");

    // Length 4097 exceeds 2**12 words.
    clear_writes();
    pulse_start();
    check("restart_code", 32'(err_code), 32'd0);
    send_seq(frame_big, 0, -1);
    check("len_error", 32'(error), 32'd1);
    check("len_code",  32'(err_code), 32'd1);
    check("len_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 8'h55;
    idle(0);
    in_valid = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    in_valid = 1'b0;
    check("len_hold_error", 32'(error), 32'd1);
    check("len_nwr", 32'(waddr_q.size()), 32'd0);

    // Empty image.
    clear_writes();
    pulse_start();
    send_seq(frame_nil, 0, -1);
    check("nil_done",  32'(done), 32'd1);
    check("nil_words", 32'(words_written), 32'd0);
    check("nil_nwr",   32'(waddr_q.size()), 32'd0);

    // Random stalls below the timeout, plus one 15-cycle stall.
    clear_writes();
    pulse_start();
    send_seq(frame_ok, 15, 6);
    check("gap_done",  32'(done), 32'd1);
    check("gap_words", 32'(words_written), 32'd2);
    check_two_writes("gap");

    // 16 idle cycles after byte 5 trips the timeout; 15 do not.
    clear_writes();
    pulse_start();
    send_seq(frame_to, 0, -1);
    idle(15);
    check("to_not_yet", 32'(error), 32'd0);
    idle(1);
    check("to_error", 32'(error), 32'd1);
    check("to_code",  32'(err_code), 32'd3);
    check("to_hold",  32'(core_hold), 32'd1);

    // N = 4096 is the largest legal image; then abort with reset mid-word.
    clear_writes();
    pulse_start();
    send_seq(frame_max, 0, -1);
    check("max_error", 32'(error), 32'd0);
    check("max_ready", 32'(in_ready), 32'd1);
    check("max_words", 32'(words_written), 32'd1);
    check("max_nwr",   32'(waddr_q.size()), 32'd1);
    if (wdata_q.size() >= 1) check("max_d0", wdata_q[0], 32'h1234_5678);

    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_idle_outputs("midrst");

    clear_writes();
    pulse_start();
    send_seq(frame_ok, 0, -1);
    check("rst_done",  32'(done), 32'd1);
    check("rst_words", 32'(words_written), 32'd2);
    check_two_writes("rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
